// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the data-RAM arbiter.
package mem_arb_pkg;

    localparam int unsigned ADDR_W_DEF = 9;
    localparam int unsigned DATA_W_DEF = 34;

    // Doubles as FSM state (last grant) and as the read-return tag.
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_PIPE = 2'd1,
        OWN_SEC  = 2'd2
    } owner_e;

endpackage

// File: rtl/arb_starve_counter.sv
// Saturating up-counter with synchronous clear; holds once it reaches LIMIT.
module arb_starve_counter #(
    parameter int unsigned  W     = 4,
    parameter logic [W-1:0] LIMIT = '1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc_i,
    input  logic         clr_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != LIMIT)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares one single-port synchronous data RAM between the pipeline (P) and a
// secondary master (S). P has priority; a starvation guard bounds S's wait.
//
//   state    | meaning
//   OWN_NONE | no grant issued last cycle
//   OWN_PIPE | P was granted last cycle
//   OWN_SEC  | S was granted last cycle
module data_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W       = ADDR_W_DEF,
    parameter int unsigned DATA_W       = DATA_W_DEF,
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned CNT_W        = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p_req,
    input  logic              p_we,
    input  logic [ADDR_W-1:0] p_addr,
    input  logic [DATA_W-1:0] p_wdata,
    output logic              p_stall,
    output logic              p_rvalid,
    output logic [DATA_W-1:0] p_rdata,
    input  logic              s_req,
    input  logic              s_we,
    input  logic [ADDR_W-1:0] s_addr,
    input  logic [DATA_W-1:0] s_wdata,
    output logic              s_gnt,
    output logic              s_rvalid,
    output logic [DATA_W-1:0] s_rdata,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_wren,
    input  logic [DATA_W-1:0] ram_q,
    output logic [CNT_W-1:0]  conflict_cnt
);

    localparam int unsigned   SW         = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_LIMIT);

    owner_e            state_q, state_d;
    owner_e            tag_q, tag_d;
    logic              gnt_p, gnt_s;
    logic [SW-1:0]     starve_cnt;
    logic              starve_hit;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] p_rdata_q, p_rdata_d;
    logic [DATA_W-1:0] s_rdata_q, s_rdata_d;

    assign starve_hit = (starve_cnt == STARVE_LIM);

    // Grants are gated by rst so every output reads 0 while reset is held.
    always_comb begin
        gnt_p = 1'b0;
        gnt_s = 1'b0;
        if (rst) begin
            if (p_req && s_req) begin
                if (STARVE_LIMIT == 0) begin
                    if (state_q == OWN_PIPE) gnt_s = 1'b1;
                    else                     gnt_p = 1'b1;
                end else if (starve_hit) begin
                    gnt_s = 1'b1;
                end else begin
                    gnt_p = 1'b1;
                end
            end else begin
                gnt_p = p_req;
                gnt_s = s_req;
            end
        end
    end

    always_comb begin
        state_d = OWN_NONE;
        tag_d   = OWN_NONE;
        if (gnt_p) begin
            state_d = OWN_PIPE;
            if (!p_we) tag_d = OWN_PIPE;
        end else if (gnt_s) begin
            state_d = OWN_SEC;
            if (!s_we) tag_d = OWN_SEC;
        end
    end

    // Address/data hold their last value when idle; only wren drops.
    always_comb begin
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        ram_wren = 1'b0;
        if (gnt_p) begin
            addr_d   = p_addr;
            wdata_d  = p_wdata;
            ram_wren = p_we;
        end else if (gnt_s) begin
            addr_d   = s_addr;
            wdata_d  = s_wdata;
            ram_wren = s_we;
        end
    end

    assign ram_address = addr_d;
    assign ram_data    = wdata_d;

    assign p_rvalid  = (tag_q == OWN_PIPE);
    assign s_rvalid  = (tag_q == OWN_SEC);
    assign p_rdata_d = p_rvalid ? ram_q : p_rdata_q;
    assign s_rdata_d = s_rvalid ? ram_q : s_rdata_q;
    assign p_rdata   = p_rdata_d;
    assign s_rdata   = s_rdata_d;

    assign p_stall = rst & p_req & ~gnt_p;
    assign s_gnt   = gnt_s;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= OWN_NONE;
            tag_q     <= OWN_NONE;
            addr_q    <= '0;
            wdata_q   <= '0;
            p_rdata_q <= '0;
            s_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            tag_q     <= tag_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            p_rdata_q <= p_rdata_d;
            s_rdata_q <= s_rdata_d;
        end
    end

    arb_starve_counter #(
        .W     (SW),
        .LIMIT (STARVE_LIM)
    ) u_starve (
        .clk   (clk),
        .rst   (rst),
        .inc_i (s_req & ~gnt_s),
        .clr_i (gnt_s | ~s_req),
        .cnt_o (starve_cnt)
    );

    arb_starve_counter #(
        .W (CNT_W)
    ) u_conflict (
        .clk   (clk),
        .rst   (rst),
        .inc_i (p_stall),
        .clr_i (1'b0),
        .cnt_o (conflict_cnt)
    );

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench: two arbiters (STARVE_LIMIT=4 and 0) share stimulus; read
// returns are checked against a scoreboard filled when grants are expected.
module tb_data_mem_arbiter;

    localparam int AW = 9;
    localparam int DW = 34;
    localparam int CW = 4;

    logic clk = 1'b0;
    logic rst;
    logic preload;
    always #5 clk = ~clk;

    logic          p_req, p_we, s_req, s_we;
    logic [AW-1:0] p_addr, s_addr;
    logic [DW-1:0] p_wdata, s_wdata;

    logic          p_stall_w [2];
    logic          p_rvalid_w[2];
    logic [DW-1:0] p_rdata_w [2];
    logic          s_gnt_w   [2];
    logic          s_rvalid_w[2];
    logic [DW-1:0] s_rdata_w [2];
    logic [AW-1:0] ram_addr_w[2];
    logic [DW-1:0] ram_data_w[2];
    logic          ram_wren_w[2];
    logic [CW-1:0] conf_w    [2];

    function automatic logic [DW-1:0] pre(input int i);
        return {2'b10, 16'hC0DE, 7'd0, 9'(i)};
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic [DW-1:0] mem [512];
        logic [DW-1:0] q;

        data_mem_arbiter #(
            .ADDR_W       (AW),
            .DATA_W       (DW),
            .STARVE_LIMIT ((g == 0) ? 4 : 0),
            .CNT_W        (CW)
        ) u_dut (
            .clk          (clk),
            .rst          (rst),
            .p_req        (p_req),
            .p_we         (p_we),
            .p_addr       (p_addr),
            .p_wdata      (p_wdata),
            .p_stall      (p_stall_w[g]),
            .p_rvalid     (p_rvalid_w[g]),
            .p_rdata      (p_rdata_w[g]),
            .s_req        (s_req),
            .s_we         (s_we),
            .s_addr       (s_addr),
            .s_wdata      (s_wdata),
            .s_gnt        (s_gnt_w[g]),
            .s_rvalid     (s_rvalid_w[g]),
            .s_rdata      (s_rdata_w[g]),
            .ram_address  (ram_addr_w[g]),
            .ram_data     (ram_data_w[g]),
            .ram_wren     (ram_wren_w[g]),
            .ram_q        (q),
            .conflict_cnt (conf_w[g])
        );

        always @(posedge clk) begin
            if (preload) begin
                for (int i = 0; i < 512; i++) mem[i] <= pre(i);
            end else begin
                if (ram_wren_w[g]) mem[ram_addr_w[g]] <= ram_data_w[g];
                q <= mem[ram_addr_w[g]];
            end
        end
    end

    typedef struct {
        int            port;
        logic [DW-1:0] data;
    } ret_t;

    ret_t          sb0[$];
    ret_t          sb1[$];
    logic [DW-1:0] exp_mem [2][512];
    logic [CW-1:0] conf_exp[2];
    logic [AW-1:0] last_addr[2];
    int            n_cmp = 0;
    int            n_mis = 0;

    task automatic chk(input string tag, input int d, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s dut%0d observed=0x%0h expected=0x%0h", tag, d, obs, exp);
        end
    endtask

    task automatic sb_push(input int d, input int port, input logic [DW-1:0] data);
        ret_t r;
        r.port = port;
        r.data = data;
        if (d == 0) sb0.push_back(r);
        else        sb1.push_back(r);
    endtask

    function automatic int sb_size(input int d);
        return (d == 0) ? sb0.size() : sb1.size();
    endfunction

    task automatic sb_pop(input int d, output ret_t r);
        if (d == 0) r = sb0.pop_front();
        else        r = sb1.pop_front();
    endtask

    task automatic idle_in();
        p_req = 1'b0; p_we = 1'b0; p_addr = '0; p_wdata = '0;
        s_req = 1'b0; s_we = 1'b0; s_addr = '0; s_wdata = '0;
    endtask

    task automatic model_reset();
        sb0.delete();
        sb1.delete();
        for (int d = 0; d < 2; d++) begin
            conf_exp[d]  = '0;
            last_addr[d] = '0;
        end
    endtask

    // One cycle: inputs already driven; check at negedge, then advance.
    task automatic tick(input bit [1:0] egp, input bit [1:0] egs);
        ret_t r;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            if (sb_size(d) > 0) begin
                sb_pop(d, r);
                chk("p_rvalid", d, p_rvalid_w[d], r.port == 0);
                chk("s_rvalid", d, s_rvalid_w[d], r.port == 1);
                if (r.port == 0) chk("p_rdata", d, p_rdata_w[d], r.data);
                else             chk("s_rdata", d, s_rdata_w[d], r.data);
            end else begin
                chk("p_rvalid_idle", d, p_rvalid_w[d], 0);
                chk("s_rvalid_idle", d, s_rvalid_w[d], 0);
            end
            chk("conflict_cnt", d, conf_w[d], conf_exp[d]);
            chk("p_stall", d, p_stall_w[d], p_req & ~egp[d]);
            chk("s_gnt", d, s_gnt_w[d], egs[d]);
            if (egp[d]) begin
                chk("ram_address_p", d, ram_addr_w[d], p_addr);
                chk("ram_wren_p", d, ram_wren_w[d], p_we);
                if (p_we) begin
                    chk("ram_data_p", d, ram_data_w[d], p_wdata);
                    exp_mem[d][p_addr] = p_wdata;
                end else begin
                    sb_push(d, 0, exp_mem[d][p_addr]);
                end
                last_addr[d] = p_addr;
            end else if (egs[d]) begin
                chk("ram_address_s", d, ram_addr_w[d], s_addr);
                chk("ram_wren_s", d, ram_wren_w[d], s_we);
                if (s_we) begin
                    chk("ram_data_s", d, ram_data_w[d], s_wdata);
                    exp_mem[d][s_addr] = s_wdata;
                end else begin
                    sb_push(d, 1, exp_mem[d][s_addr]);
                end
                last_addr[d] = s_addr;
            end else begin
                chk("ram_wren_idle", d, ram_wren_w[d], 0);
                chk("ram_address_hold", d, ram_addr_w[d], last_addr[d]);
            end
            if (p_req && !egp[d] && conf_exp[d] != 4'hF) conf_exp[d] = conf_exp[d] + 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic contend(input int n);
        bit [1:0] es;
        p_req = 1'b1; p_we = 1'b0; p_addr = 9'h001;
        s_req = 1'b1; s_we = 1'b0; s_addr = 9'h002;
        for (int i = 0; i < n; i++) begin
            es[0] = (i % 5 == 4);
            es[1] = (i % 2 == 1);
            tick(~es, es);
        end
        idle_in();
        tick(2'b00, 2'b00);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst     = 1'b0;
        preload = 1'b1;
        idle_in();
        model_reset();
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 512; i++) exp_mem[d][i] = pre(i);
        @(posedge clk);
        #1;
        preload = 1'b0;

        // Reset held with random inputs: everything must read 0.
        for (int k = 0; k < 4; k++) begin
            p_req = 1'($urandom); p_we = 1'($urandom);
            p_addr = 9'($urandom); p_wdata = 34'({$urandom(), $urandom()});
            s_req = 1'($urandom); s_we = 1'($urandom);
            s_addr = 9'($urandom); s_wdata = 34'({$urandom(), $urandom()});
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                chk("rst_p_stall", d, p_stall_w[d], 0);
                chk("rst_p_rvalid", d, p_rvalid_w[d], 0);
                chk("rst_p_rdata", d, p_rdata_w[d], 0);
                chk("rst_s_gnt", d, s_gnt_w[d], 0);
                chk("rst_s_rvalid", d, s_rvalid_w[d], 0);
                chk("rst_s_rdata", d, s_rdata_w[d], 0);
                chk("rst_ram_address", d, ram_addr_w[d], 0);
                chk("rst_ram_data", d, ram_data_w[d], 0);
                chk("rst_ram_wren", d, ram_wren_w[d], 0);
                chk("rst_conflict_cnt", d, conf_w[d], 0);
            end
            @(posedge clk);
            #1;
        end
        idle_in();
        rst = 1'b1;

        // First read after release returns the preloaded word.
        p_req = 1'b1; p_we = 1'b0; p_addr = 9'h005;
        tick(2'b11, 2'b00);
        idle_in();
        tick(2'b00, 2'b00);

        // P write then read-back; S write then read-back.
        p_req = 1'b1; p_we = 1'b1; p_addr = 9'h010; p_wdata = 34'h2A5;
        tick(2'b11, 2'b00);
        p_we = 1'b0; p_wdata = '0;
        tick(2'b11, 2'b00);
        idle_in();
        s_req = 1'b1; s_we = 1'b1; s_addr = 9'h020; s_wdata = 34'h3_0000_0001;
        tick(2'b00, 2'b11);
        s_we = 1'b0; s_wdata = '0;
        tick(2'b00, 2'b11);
        idle_in();
        tick(2'b00, 2'b00);

        // Contention: dut0 grants S every 5th cycle, dut1 alternates.
        contend(10);

        // Reset while an S read is in flight.
        s_req = 1'b1; s_we = 1'b0; s_addr = 9'h002;
        @(negedge clk);
        for (int d = 0; d < 2; d++) chk("s_gnt_before_rst", d, s_gnt_w[d], 1);
        rst = 1'b0;
        idle_in();
        model_reset();
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                chk("s_rvalid_in_rst", d, s_rvalid_w[d], 0);
                chk("p_rvalid_in_rst", d, p_rvalid_w[d], 0);
            end
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        tick(2'b00, 2'b00);
        contend(5);

        // Saturation of the 4-bit conflict counter.
        contend(100);
        for (int d = 0; d < 2; d++) chk("conflict_saturated", d, conf_w[d], 4'hF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
